approx_prod_accumulator: RTL and testbench



---
 rtl/approx_mul_pkg.sv | 14 +
 rtl/sat_add_u.sv | 21 ++
 rtl/approx_prod_accumulator.sv | 130 +++++++++++++
 tb/tb_approx_prod_accumulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared widths, defaults and FSM states for the product accumulator
package approx_mul_pkg;

  localparam int PROD_W      = 16;
  localparam int ACC_W_DEF   = 20;
  localparam int MAX_LEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/sat_add_u.sv
// rtl/sat_add_u.sv - unsigned saturating adder, A_W + B_W -> A_W with saturation flag
module sat_add_u #(
  parameter int A_W = 20,
  parameter int B_W = 16
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           sat
);

  logic [A_W:0] sum_full;

  // One extra carry bit exposes overflow; clamp to all-ones when it is set
  always_comb begin
    sum_full = {1'b0, a} + {{(A_W - B_W + 1){1'b0}}, b};
    sat      = sum_full[A_W];
    sum      = sat ? {A_W{1'b1}} : sum_full[A_W-1:0];
  end

endmodule

// File: rtl/approx_prod_accumulator.sv
// rtl/approx_prod_accumulator.sv - streaming saturating sum of multiplier products per vector
module approx_prod_accumulator
  import approx_mul_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sync_clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PROD_W-1:0]                in_prod,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]     out_cnt,
  output logic                             out_ovf
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] sum_next;
  logic             sat_now;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             terminal;

  sat_add_u #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_prod),
    .sum (sum_next),
    .sat (sat_now)
  );

  // A drain and a new beat can share a cycle, so readiness looks through out_ready
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    beat     = in_valid && in_ready;
    cnt_inc  = cnt_q + 1'b1;
    terminal = in_last || (cnt_inc == CNT_W'(MAX_LEN));
  end

  // Next-state, accumulator and result-register update; sync_clr overrides everything
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end

    // acc/cnt are already zero after a terminal beat, so a beat during a drain
    // naturally starts a fresh vector from in_prod
    if (beat) begin
      if (terminal) begin
        out_sum_d   = sum_next;
        out_cnt_d   = cnt_inc;
        out_ovf_d   = ovf_q || sat_now;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_d   = sum_next;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q || sat_now;
        state_d = ACCUM;
      end
    end

    if (sync_clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// tb/tb_approx_prod_accumulator.sv - directed self-checking bench for approx_prod_accumulator
module tb_approx_prod_accumulator;

  localparam int ACC_W   = 20;
  localparam int MAX_LEN = 32;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             sync_clr;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  int tests;
  int fails;

  approx_prod_accumulator #(
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one beat across the next rising edge, then sample 1 time unit later
  task automatic send_beat(input logic [15:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    sync_clr  = 1'b0;
    in_valid  = 1'b1;
    in_prod   = 16'hFFFF;
    in_last   = 1'b1;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (out_sum !== '0) begin fails++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    tests++; if (out_cnt !== '0) begin fails++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf got %0b want 0", out_ovf); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_vector();
    out_ready = 1'b1;
    send_beat(16'd65025, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
    send_beat(16'd100, 1'b0);
    send_beat(16'd1, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    tests++; if (out_sum !== 20'd65126) begin fails++; $display("FAIL basic_sum got %0d want 65126", out_sum); end
    tests++; if (out_cnt !== 6'd3) begin fails++; $display("FAIL basic_cnt got %0d want 3", out_cnt); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got %0b want 0", out_ovf); end
    idle_cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_saturate_forced_end();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_beat(16'd65025, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_valid_at17 got %0b want 0", out_valid); end
    for (int i = 17; i < 31; i++) send_beat(16'd65025, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_valid_at31 got %0b want 0", out_valid); end
    send_beat(16'd65025, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sat_valid got %0b want 1", out_valid); end
    tests++; if (out_sum !== 20'd1048575) begin fails++; $display("FAIL sat_sum got %0d want 1048575", out_sum); end
    tests++; if (out_cnt !== 6'd32) begin fails++; $display("FAIL sat_cnt got %0d want 32", out_cnt); end
    tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf got %0b want 1", out_ovf); end
    idle_cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_valid_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_beat(16'd3, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_hold_valid got %0b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready cyc %0d got %0b want 0", i, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_sum !== 20'd3 || out_cnt !== 6'd1) begin
        fails++; $display("FAIL b2b_stable cyc %0d got v=%0b s=%0d c=%0d want v=1 s=3 c=1", i, out_valid, out_sum, out_cnt);
      end
      idle_cycle();
    end
    out_ready = 1'b1;
    send_beat(16'd7, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_no_bubble got %0b want 1", out_valid); end
    tests++; if (out_sum !== 20'd7) begin fails++; $display("FAIL b2b_sum got %0d want 7", out_sum); end
    tests++; if (out_cnt !== 6'd1) begin fails++; $display("FAIL b2b_cnt got %0d want 1", out_cnt); end
    idle_cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_sync_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(16'd10, 1'b0);
    sync_clr = 1'b1;
    send_beat(16'd10, 1'b1);
    sync_clr = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_no_result got %0b want 0", out_valid); end
    idle_cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_no_result_late got %0b want 0", out_valid); end
    send_beat(16'd5, 1'b1);
    tests++; if (out_valid !== 1'b1 || out_sum !== 20'd5 || out_cnt !== 6'd1) begin
      fails++; $display("FAIL clr_next_vec got v=%0b s=%0d c=%0d want v=1 s=5 c=1", out_valid, out_sum, out_cnt);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset_hold();
    out_ready = 1'b0;
    send_beat(16'd9, 1'b1);
    tests++; if (out_valid !== 1'b1 || out_sum !== 20'd9) begin
      fails++; $display("FAIL arst_pre got v=%0b s=%0d want v=1 s=9", out_valid, out_sum);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %0b want 0", out_valid); end
    tests++; if (out_sum !== '0) begin fails++; $display("FAIL arst_sum got %0d want 0", out_sum); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_beat(16'd2, 1'b0);
    send_beat(16'd4, 1'b1);
    tests++; if (out_valid !== 1'b1 || out_sum !== 20'd6 || out_cnt !== 6'd2) begin
      fails++; $display("FAIL arst_next_vec got v=%0b s=%0d c=%0d want v=1 s=6 c=2", out_valid, out_sum, out_cnt);
    end
    idle_cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_vector();
    test_saturate_forced_end();
    test_back_to_back();
    test_sync_clr();
    test_async_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
